// File: rtl/fp_add_arbiter_if.sv
// Bus bundle between the FPU front-ends, the fp_add_arbiter and the shared fp_add unit.
// The slave modport is the arbiter's view; the master modport is the surrounding environment's view.
interface fp_add_arbiter_if #(
    parameter int N   = 4,
    parameter int W   = 32,
    parameter int IDW = 2
);
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*3-1:0] req_rm;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_data;
    logic [3:0]     rsp_flags;

    logic [W-1:0]   fu_in1;
    logic [W-1:0]   fu_in2;
    logic [2:0]     fu_rm;
    logic           fu_act;
    logic [W-1:0]   fu_out;
    logic           fu_ov;
    logic           fu_un;
    logic           fu_inv;
    logic           fu_inexact;
    logic           fu_done;

    logic           busy;

    modport slave (
        input  req_valid, req_a, req_b, req_rm, rsp_ready,
        input  fu_out, fu_ov, fu_un, fu_inv, fu_inexact, fu_done,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags,
        output fu_in1, fu_in2, fu_rm, fu_act, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_rm, rsp_ready,
        output fu_out, fu_ov, fu_un, fu_inv, fu_inexact, fu_done,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags,
        input  fu_in1, fu_in2, fu_rm, fu_act, busy
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin sequencer sharing one fixed-latency fp_add among N requesters.
// Handshakes: a transfer happens on a clock edge where valid and ready are both high; valid never waits on ready.
module fp_add_arbiter #(
    parameter int N   = 4,
    parameter int W   = 32,
    parameter int LAT = 2,
    parameter int IDW = 2
) (
    input  logic                clk,
    input  logic                rst,
    fp_add_arbiter_if.slave     bus,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int CW = $clog2(LAT + 1);

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   op_a_q, op_a_d;
    logic [W-1:0]   op_b_q, op_b_d;
    logic [2:0]     op_rm_q, op_rm_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;
    logic [3:0]     rsp_flags_q, rsp_flags_d;

    logic [W-1:0]   a_arr  [N];
    logic [W-1:0]   b_arr  [N];
    logic [2:0]     rm_arr [N];
    logic           pick_found;
    logic [IDW-1:0] pick_id;
    logic [IDW-1:0] jj;
    logic [N-1:0]   req_ready_c;
    logic           unused_fu_done;

    assign unused_fu_done = bus.fu_done;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_arr[i]  = bus.req_a[i*W +: W];
            b_arr[i]  = bus.req_b[i*W +: W];
            rm_arr[i] = bus.req_rm[i*3 +: 3];
        end
    end

    // Search starts one past the last winner so every holder is served within N-1 grants.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        jj         = '0;
        for (int k = 1; k <= N; k++) begin
            jj = IDW'((int'(rr_ptr_q) + k) % N);
            if (!pick_found && bus.req_valid[jj]) begin
                pick_found = 1'b1;
                pick_id    = jj;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_rm_d     = op_rm_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        req_ready_c = '0;
        case (state_q)
            IDLE: begin
                if (pick_found && rst) begin
                    req_ready_c = N'(1) << pick_id;
                    op_a_d      = a_arr[pick_id];
                    op_b_d      = b_arr[pick_id];
                    op_rm_d     = rm_arr[pick_id];
                    id_d        = pick_id;
                    rr_ptr_d    = pick_id;
                    cnt_d       = '0;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(LAT)) begin
                    rsp_data_d  = bus.fu_out;
                    rsp_flags_d = {bus.fu_ov, bus.fu_un, bus.fu_inv, bus.fu_inexact};
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDW'(N - 1);
            id_q        <= '0;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_rm_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_rm_q     <= op_rm_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    // The adder has combinational paths to its output, so its inputs come straight from held registers.
    assign bus.fu_in1    = op_a_q;
    assign bus.fu_in2    = op_b_q;
    assign bus.fu_rm     = op_rm_q;
    assign bus.fu_act    = (state_q == EXEC);
    assign bus.busy      = (state_q != IDLE);
    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: stand-in fixed-latency adder, table of single adds, scoreboard on the response
// channel, and hand-written sequences for round-robin, backpressure, reset mid-flight and operand stability.
module tb_fp_add_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 2;
    localparam int IDW = 2;

    logic       clk;
    logic       rst;
    logic [1:0] dut_state;

    fp_add_arbiter_if #(.N(N), .W(W), .IDW(IDW)) bus ();

    fp_add_arbiter #(.N(N), .W(W), .LAT(LAT), .IDW(IDW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (dut_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stand-in adder ----------------
    // {flags, data}; two real IEEE cases, otherwise a deterministic scramble that depends on rm.
    function automatic logic [35:0] fake_add(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
        if ((a == 32'h7F800000 && b == 32'hFF800000) || (a == 32'hFF800000 && b == 32'h7F800000))
            return {4'b0010, 32'h7FC00000};
        if (a == 32'h3F800000 && b == 32'h40000000)
            return {4'b0000, 32'h40400000};
        return {rm[2], rm[1], 1'b0, a[0] ^ b[0], a + b + {29'b0, rm}};
    endfunction

    logic [35:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= fake_add(bus.fu_in1, bus.fu_in2, bus.fu_rm);
        for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end
    assign {bus.fu_ov, bus.fu_un, bus.fu_inv, bus.fu_inexact, bus.fu_out} = pipe[LAT-1];

    always @(negedge clk) bus.fu_done = 1'($urandom_range(0, 1));

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_fail = 0;
    logic [37:0] exp_q [$];
    int          hs_edges [$];
    int          last_hs_edge = 0;
    logic        rv_prev = 1'b0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    function automatic logic [37:0] mk_exp(input int id, input logic [35:0] fa);
        return {IDW'(id), fa};
    endfunction

    always @(negedge clk) begin
        logic [37:0] e;
        if (rst) begin
            if (bus.req_ready != '0) begin
                chk("ready_onehot", 64'($countones(bus.req_ready)), 64'd1);
                chk("ready_without_valid", 64'(bus.req_ready & ~bus.req_valid), 64'd0);
                last_hs_edge = cyc + 1;
                hs_edges.push_back(cyc + 1);
            end
            if (bus.rsp_valid && !rv_prev)
                chk("rsp_latency", 64'(cyc - last_hs_edge), 64'(LAT + 1));
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("rsp", 64'({bus.rsp_id, bus.rsp_flags, bus.rsp_data}), 64'(e));
                end
            end
            rv_prev = bus.rsp_valid;
        end else begin
            rv_prev = 1'b0;
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
        bus.req_a[id*W +: W] = a;
        bus.req_b[id*W +: W] = b;
        bus.req_rm[id*3 +: 3] = rm;
    endtask

    task automatic send(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                        input logic [37:0] expv, input bit chk_same);
        int n;
        set_req(id, a, b, rm);
        bus.req_valid[id] = 1'b1;
        exp_q.push_back(expv);
        n = 0;
        @(negedge clk);
        while (!bus.req_ready[id] && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("grant_timeout", 64'(n >= 50), 64'd0);
        if (chk_same) chk("ready_same_cycle", 64'(n), 64'd0);
        @(posedge clk); #1;
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("rsp_timeout", 64'(n >= 50), 64'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rm;
        logic [31:0] exp_d;
        logic [3:0]  exp_f;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [31:0] ra, rb, rr_a [N], rr_b [N];
        logic [2:0]  rrm;
        logic [35:0] fa;
        int          n;

        tbl[0] = '{id: 2, a: 32'h3F800000, b: 32'h40000000, rm: 3'b000, exp_d: 32'h40400000, exp_f: 4'b0000};
        tbl[1] = '{id: 1, a: 32'h7F800000, b: 32'hFF800000, rm: 3'b000, exp_d: 32'h7FC00000, exp_f: 4'b0010};
        for (int i = 2; i < 6; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rrm = 3'($urandom_range(0, 4));
            fa  = fake_add(ra, rb, rrm);
            tbl[i] = '{id: $urandom_range(0, N-1), a: ra, b: rb, rm: rrm, exp_d: fa[31:0], exp_f: fa[35:32]};
        end

        // reset with every requester already valid
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_rm = '0;
        for (int i = 0; i < N; i++) begin
            rr_a[i] = $urandom;
            rr_b[i] = $urandom;
            set_req(i, rr_a[i], rr_b[i], 3'(i));
        end
        bus.req_valid = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset_rsp", 64'({bus.rsp_id, bus.rsp_flags, bus.rsp_data}), 64'd0);
        chk("reset_fu_in", 64'({bus.fu_in1, bus.fu_in2}), 64'd0);
        chk("reset_fu_rm_act", 64'({bus.fu_rm, bus.fu_act}), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_state", 64'(dut_state), 64'd0);

        // round-robin from reset: 0,1,2,3,0 at LAT+3 spacing
        for (int k = 0; k < 5; k++) exp_q.push_back(mk_exp(k % N, fake_add(rr_a[k % N], rr_b[k % N], 3'(k % N))));
        hs_edges.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        n = 0;
        while (hs_edges.size() < 5 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("rr_timeout", 64'(n >= 100), 64'd0);
        @(posedge clk); #1;
        bus.req_valid = '0;
        if (hs_edges.size() >= 5)
            for (int k = 1; k < 5; k++) chk("rr_spacing", 64'(hs_edges[k] - hs_edges[k-1]), 64'(LAT + 3));
        wait_idle();

        // table of single adds
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].rm, mk_exp(tbl[i].id, {tbl[i].exp_f, tbl[i].exp_d}), i == 0);
            wait_idle();
        end

        // backpressure: response held, other requesters ignored
        bus.rsp_ready = 1'b0;
        ra = 32'h12345678;
        rb = 32'h0BADF00D;
        fa = fake_add(ra, rb, 3'b001);
        send(0, ra, rb, 3'b001, mk_exp(0, fa), 1'b0);
        set_req(1, 32'hDEAD0001, 32'hBEEF0001, 3'b010);
        set_req(3, 32'hDEAD0003, 32'hBEEF0003, 3'b100);
        bus.req_valid[1] = 1'b1;
        bus.req_valid[3] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("bp_rsp_timeout", 64'(n >= 20), 64'd0);
        for (int c = 0; c < 10; c++) begin
            chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_rsp_hold", 64'({bus.rsp_id, bus.rsp_flags, bus.rsp_data}), 64'(mk_exp(0, fa)));
            chk("bp_busy_ready", 64'({bus.busy, bus.req_ready}), 64'h10);
            chk("bp_fu_in", 64'({bus.fu_in1, bus.fu_in2}), 64'({ra, rb}));
            if (c < 9) @(negedge clk);
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_idle", 64'({dut_state, bus.busy, bus.rsp_valid}), 64'd0);
        @(posedge clk); #1;

        // operand stability: bus changes during EXEC must not reach the adder
        ra = 32'h40A00000;
        rb = 32'h3E800000;
        send(2, ra, rb, 3'b011, mk_exp(2, fake_add(ra, rb, 3'b011)), 1'b0);
        set_req(2, 32'hFFFF0000, 32'h0000FFFF, 3'b000);
        for (int c = 0; c < LAT + 1; c++) begin
            @(negedge clk);
            chk("stab_fu_in1", 64'(bus.fu_in1), 64'(ra));
            chk("stab_fu_rm_act", 64'({bus.fu_rm, bus.fu_act}), 64'({3'b011, 1'b1}));
        end
        wait_idle();

        // reset one cycle into EXEC: operation dropped, requester 0 wins afterwards
        send(1, 32'h11111111, 32'h22222222, 3'b000, 38'd0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_mid_outputs", 64'({bus.rsp_valid, bus.fu_act, bus.busy, bus.fu_rm, bus.req_ready}), 64'd0);
        chk("rst_mid_fu_in", 64'({bus.fu_in1, bus.fu_in2}), 64'd0);
        chk("rst_mid_rsp", 64'({bus.rsp_id, bus.rsp_flags, bus.rsp_data}), 64'd0);
        set_req(0, 32'h01010101, 32'h02020202, 3'b100);
        set_req(3, 32'h03030303, 32'h04040404, 3'b001);
        exp_q.push_back(mk_exp(0, fake_add(32'h01010101, 32'h02020202, 3'b100)));
        bus.req_valid[0] = 1'b1;
        bus.req_valid[3] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        n = 0;
        @(negedge clk);
        while (bus.req_ready == '0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("rst_next_grant", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_idle();

        // drain: nothing else may come out
        repeat (10) @(negedge clk);
        chk("leftover_expected", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Round-robin arbiter and sequencer that shares one `fp_add` unit among `N` requesters. It accepts one add request at a time over per-requester valid/ready handshakes and drives the operands and rounding mode into the adder. It holds those inputs stable for the adder's full latency, then captures the result and exception flags. Results return on a single response channel tagged with the requester index. The block sits between the FPU instruction front-ends and the adder instance.

## Interface
- `N`, 4: number of requesters (2..8).
- `W`, 32: operand width.
- `LAT`, 2: `fp_add` latency in clock edges from stable inputs to registered output.
- `IDW`, 2: requester-index width; must satisfy 2^IDW >= N.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  N  per-requester request valid.
- `req_ready`  out  N  per-requester accept; at most one bit high.
- `req_a`  in  N*W  operand A; requester i in bits [i*W +: W].
- `req_b`  in  N*W  operand B; same packing as `req_a`.
- `req_rm`  in  N*3  rounding mode; requester i in bits [i*3 +: 3].
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_data`  out  W  sum.
- `rsp_flags`  out  4  {ov, un, inv, inexact}.
- `fu_in1`, `fu_in2`  out  W  adder operands.
- `fu_rm`  out  3  adder `round_m`.
- `fu_act`  out  1  adder activate.
- `fu_out`  in  W  adder result.
- `fu_ov`, `fu_un`, `fu_inv`, `fu_inexact`, `fu_done`  in  1  adder flags.
- `busy`  out  1  high whenever the FSM is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Round-robin pick: the lowest index at or after `rr_ptr+1` (mod N) with `req_valid` high. `req_ready` is asserted combinationally only for the picked index.
  - On handshake: latch a/b/rm into operand registers, record `id`, set `rr_ptr<=id`, clear `cnt`, go to EXEC.
  - With no `req_valid` bits high: all `req_ready` = 0 and the FSM stays in IDLE.
- **EXEC**
  - `fu_act`=1. `fu_in1`/`fu_in2`/`fu_rm` come from the operand registers, which are unchanged throughout EXEC and RESP. The adder has combinational paths into its output stage, so its inputs must not change while an operation is in flight.
  - `cnt` increments each cycle.
  - At the edge where `cnt==LAT`: capture `fu_out` into `rsp_data`, {`fu_ov`,`fu_un`,`fu_inv`,`fu_inexact`} into `rsp_flags`, and `id` into `rsp_id`. Set `rsp_valid`=1 and go to RESP.
  - `fu_done` is ignored for sequencing; the latency is fixed.
- **RESP**
  - `rsp_*` are held stable while `rsp_valid`=1 and `rsp_ready`=0.
  - On `rsp_valid & rsp_ready`: clear `rsp_valid` and go to IDLE.
  - No new request is accepted in the same cycle; this gives a one-idle-cycle turnaround.
- `fu_act`=0 in IDLE and RESP. Operand registers keep their last value outside EXEC.
- Requests whose `req_valid` drops before grant are simply not served; there is no queuing inside the block.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_flags`=0, `fu_in1`=`fu_in2`=0, `fu_rm`=0, `fu_act`=0, `busy`=0, `rr_ptr`=N-1 (requester 0 wins first), state=IDLE, `cnt`=0.
- Handshake at edge T → EXEC from T. `cnt` is 0 after T, 1 after T+1, LAT after T+LAT. Capture happens at edge T+LAT+1, and `rsp_valid` is high after T+LAT+1.
- Minimum issue interval is LAT+3 cycles, with `rsp_ready` held at 1.
- Reset asserted mid-EXEC or mid-RESP immediately returns the block to reset values. The in-flight operation is dropped, and no response is produced after reset is released.
- Simultaneous requests: exactly one `req_ready` per grant. Fairness: no requester waits more than N-1 grants while it holds `req_valid`.
- `rr_ptr` wraps from N-1 to 0.
- `req_ready` depends combinationally on `req_valid` and on the state.

## Test plan
- Single add: requester 2 sends a=0x3F800000, b=0x40000000, rm=RNe. Expect `req_ready[2]` high in the same cycle. Expect `rsp_valid` 3 edges later with `rsp_id`=2, `rsp_data`=0x40400000, `rsp_flags`=0.
- Round-robin: all 4 requesters hold `req_valid` continuously from reset with `rsp_ready`=1. Expect grant order 0,1,2,3,0. Expect each response tagged correctly and spaced 5 cycles apart.
- Backpressure: hold `rsp_ready`=0 for 10 cycles after `rsp_valid`. Expect `rsp_*` stable, `busy`=1, all `req_ready`=0, and `fu_in1`/`fu_in2` unchanged. Release: IDLE next cycle.
- Exception pass-through: send +inf (0x7F800000) + -inf (0xFF800000). Expect `rsp_data`=quiet NaN and `rsp_flags`={0,0,1,0}.
- Reset mid-EXEC: deassert `rst` one cycle after the handshake. Expect all outputs at reset values and no `rsp_valid` after `rst` rises. The next request is granted to requester 0 if it is valid.
- Operand stability: request with rm=RU, then change `req_a`/`req_rm` on the bus during EXEC. Expect `fu_in1`/`fu_rm` unchanged and the result computed from the latched values.
